// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//  - funct3 access-mode codes (B/H/W/BU/HU)
//  - FSM state encoding (2-bit)
//  - funct3_size(): access size in bytes, 0 for an undefined mode
package load_store_unit_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic [2:0] funct3_size(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_B, FUNCT3_BU: funct3_size = 3'd1;
      FUNCT3_H, FUNCT3_HU: funct3_size = 3'd2;
      FUNCT3_W:            funct3_size = 3'd4;
      default:             funct3_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the load/store unit's handshake and memory buses.
//  req_*  : op offered by the execute stage (valid/ready)
//  mem_*  : byte-addressed big-endian data memory port
//  resp_* : completion returned to writeback (valid/ready)
// slave  = the load/store unit itself; master = its environment.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic [31:0] mem_address;
  logic [31:0] mem_write;
  logic        mem_is_read;
  logic        mem_is_write;
  logic [2:0]  mem_mode;
  logic [31:0] mem_read;

  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
    input  mem_read, resp_ready,
    output req_ready,
    output mem_address, mem_write, mem_is_read, mem_is_write, mem_mode,
    output resp_valid, resp_rd, resp_data, resp_err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
    output mem_read, resp_ready,
    input  req_ready,
    input  mem_address, mem_write, mem_is_read, mem_is_write, mem_mode,
    input  resp_valid, resp_rd, resp_data, resp_err
  );
endinterface

// File: rtl/load_store_unit_addr_check.sv
// Address formation and legality check (purely combinational).
//  base_i     : rs1 value
//  offset_i   : signed 12-bit immediate
//  funct3_i   : access mode
//  is_store_i : 1 for stores
//  addr_o     : base + sext(offset), modulo 2^32
//  err_o      : undefined mode, store with an unsigned mode, or any byte past MEM_BYTES-1
module load_store_unit_addr_check
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic               [31:0] base_i,
  input  logic signed        [11:0] offset_i,
  input  logic               [2:0]  funct3_i,
  input  logic                      is_store_i,
  output logic               [31:0] addr_o,
  output logic                      err_o
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  logic signed [31:0] offset_sext;
  logic        [2:0]  size;
  logic        [32:0] end_excl;

  assign offset_sext = 32'(offset_i);
  assign addr_o      = base_i + offset_sext;
  assign size        = funct3_size(funct3_i);
  // 33-bit end address so an access wrapping past 2^32 is still out of range.
  assign end_excl    = {1'b0, addr_o} + {30'b0, size};

  assign err_o = (size == 3'd0) || (is_store_i && funct3_i[2]) || (end_excl > MEM_LIMIT);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one op from execute, drives the data memory for one
// ISSUE cycle, waits MEM_LATENCY cycles for load data, and holds the completion
// until writeback takes it. Illegal ops answer with resp_err and no memory access.
//  clk, rst_n : clock, synchronous active-low reset
//  bus        : req_* / mem_* / resp_* (see load_store_unit_if)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 65536,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  lsu_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  mode_q, mode_d;
  logic        store_q, store_d;
  logic [4:0]  rd_q, rd_d;
  logic        resp_err_q, resp_err_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic [31:0] chk_addr;
  logic        chk_err;

  load_store_unit_addr_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_addr_check (
    .base_i     (bus.req_base),
    .offset_i   (bus.req_offset),
    .funct3_i   (bus.req_funct3),
    .is_store_i (bus.req_is_store),
    .addr_o     (chk_addr),
    .err_o      (chk_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mode_d      = mode_q;
    store_d     = store_q;
    rd_d        = rd_q;
    resp_err_d  = resp_err_q;
    resp_rd_d   = resp_rd_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (chk_err) begin
            // Memory-side registers keep their last values on a rejected op.
            resp_err_d  = 1'b1;
            resp_rd_d   = '0;
            resp_data_d = '0;
            state_d     = ST_RESP;
          end else begin
            addr_d  = chk_addr;
            wdata_d = bus.req_wdata;
            mode_d  = bus.req_funct3;
            store_d = bus.req_is_store;
            rd_d    = bus.req_rd;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (store_q) begin
          resp_err_d  = 1'b0;
          resp_rd_d   = '0;
          resp_data_d = '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d   = 3'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT) begin
          resp_err_d  = 1'b0;
          resp_rd_d   = rd_q;
          resp_data_d = bus.mem_read;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= '0;
      resp_err_q  <= 1'b0;
      resp_rd_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      resp_err_q  <= resp_err_d;
      resp_rd_q   <= resp_rd_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Op attributes only matter once an op is in flight, so they carry no reset.
  always_ff @(posedge clk) begin
    store_q <= store_d;
    rd_q    <= rd_d;
  end

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.resp_valid   = (state_q == ST_RESP);
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_rd      = resp_rd_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.mem_address  = addr_q;
  assign bus.mem_write    = wdata_q;
  assign bus.mem_mode     = mode_q;
  // Gated by rst_n so a reset landing on ISSUE cannot commit a write.
  assign bus.mem_is_read  = rst_n && (state_q == ST_ISSUE) && !store_q;
  assign bus.mem_is_write = rst_n && (state_q == ST_ISSUE) && store_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   strobes0;

  logic        ram_init;
  logic        bd_we0, bd_we1;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  logic [7:0]  ram0 [0:65535];
  logic [7:0]  ram1 [0:65535];
  logic [7:0]  refm [0:65535];
  logic [31:0] pend0, pend1;
  int          cnt0, cnt1;

  load_store_unit_if if0 ();
  load_store_unit_if if1 ();

  load_store_unit #(.MEM_BYTES(65536), .MEM_LATENCY(LAT0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  load_store_unit #(.MEM_BYTES(65536), .MEM_LATENCY(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + (i >> 8) * 11 + 5);
  endfunction

  // Memory device: registered, already-extended read data after LAT cycles.
  function automatic logic [31:0] dev_ext(input logic [2:0] m, input logic [31:0] w);
    case (m)
      3'b000:  return {{24{w[31]}}, w[31:24]};
      3'b100:  return {24'b0, w[31:24]};
      3'b001:  return {{16{w[31]}}, w[31:16]};
      3'b101:  return {16'b0, w[31:16]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_init) for (int i = 0; i < 65536; i++) ram0[i] <= pat(i);
    if (bd_we0) ram0[bd_addr] <= bd_data;
    if (if0.mem_is_write) begin
      case (if0.mem_mode)
        3'b000: ram0[if0.mem_address[15:0]] <= if0.mem_write[7:0];
        3'b001: begin
          ram0[if0.mem_address[15:0]]         <= if0.mem_write[15:8];
          ram0[if0.mem_address[15:0] + 16'd1] <= if0.mem_write[7:0];
        end
        default: begin
          ram0[if0.mem_address[15:0]]         <= if0.mem_write[31:24];
          ram0[if0.mem_address[15:0] + 16'd1] <= if0.mem_write[23:16];
          ram0[if0.mem_address[15:0] + 16'd2] <= if0.mem_write[15:8];
          ram0[if0.mem_address[15:0] + 16'd3] <= if0.mem_write[7:0];
        end
      endcase
    end
    if (if0.mem_is_read) begin
      if (LAT0 == 1) begin
        if0.mem_read <= dev_ext(if0.mem_mode, {ram0[if0.mem_address[15:0]],
          ram0[if0.mem_address[15:0] + 16'd1], ram0[if0.mem_address[15:0] + 16'd2],
          ram0[if0.mem_address[15:0] + 16'd3]});
      end else begin
        pend0 <= dev_ext(if0.mem_mode, {ram0[if0.mem_address[15:0]],
          ram0[if0.mem_address[15:0] + 16'd1], ram0[if0.mem_address[15:0] + 16'd2],
          ram0[if0.mem_address[15:0] + 16'd3]});
        cnt0 <= LAT0 - 1;
        if0.mem_read <= 32'hBAD0BAD0;
      end
    end else if (cnt0 != 0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) if0.mem_read <= pend0;
    end
  end

  always @(posedge clk) begin
    if (ram_init) for (int i = 0; i < 65536; i++) ram1[i] <= pat(i);
    if (bd_we1) ram1[bd_addr] <= bd_data;
    if (if1.mem_is_read) begin
      pend1 <= dev_ext(if1.mem_mode, {ram1[if1.mem_address[15:0]],
        ram1[if1.mem_address[15:0] + 16'd1], ram1[if1.mem_address[15:0] + 16'd2],
        ram1[if1.mem_address[15:0] + 16'd3]});
      cnt1 <= LAT1 - 1;
      if1.mem_read <= 32'hBAD0BAD0;
    end else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 1;
      if (cnt1 == 1) if1.mem_read <= pend1;
    end
  end

  always @(posedge clk) begin
    if (if0.mem_is_read || if0.mem_is_write) strobes0 <= strobes0 + 1;
  end

  // Reference model: byte array plus arithmetic on access sizes.
  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    longint v = 0;
    int sz = ref_size(f3);
    for (int i = 0; i < sz; i++) v = v * 256 + longint'(refm[16'(a + 32'(i))]);
    if (f3[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int sz = ref_size(f3);
    for (int i = 0; i < sz; i++) refm[16'(a + 32'(i))] = 8'(wd >> (8 * (sz - 1 - i)));
  endtask

  task automatic poke(input bit which, input logic [15:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    if (which) bd_we1 = 1'b1;
    else begin
      bd_we0  = 1'b1;
      refm[a] = d;
    end
    @(posedge clk); #1;
    bd_we0 = 1'b0;
    bd_we1 = 1'b0;
  endtask

  task automatic drive0(input bit st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd);
    if0.req_is_store = st;
    if0.req_funct3   = f3;
    if0.req_base     = base;
    if0.req_offset   = off;
    if0.req_wdata    = wd;
    if0.req_rd       = rd;
    if0.req_valid    = 1'b1;
  endtask

  task automatic run_op(input string nm, input bit st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [11:0] off,
                        input logic [31:0] wd, input logic [4:0] rd, output logic [31:0] got);
    logic [31:0] a, exp_d;
    logic [4:0]  exp_rd;
    bit          e;
    int          lat, n, s0;
    a      = base + {{20{off[11]}}, off};
    e      = (ref_size(f3) == 0) || (st && f3[2]) || (longint'(a) + ref_size(f3) > 65536);
    exp_d  = '0;
    exp_rd = '0;
    if (!e && !st) begin
      exp_d  = ref_load(a, f3);
      exp_rd = rd;
    end
    if (!e && st) ref_store(a, f3, wd);
    lat = e ? 0 : (st ? 1 : 1 + LAT0);
    s0  = strobes0;
    drive0(st, f3, base, off, wd, rd);
    n = 0;
    while (!if0.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    if (!e) begin
      checks++;
      if (if0.mem_is_read !== !st || if0.mem_is_write !== st || if0.mem_address !== a ||
          if0.mem_mode !== f3 || (st && if0.mem_write !== wd)) begin
        errors++;
        $display("FAIL %s issue: rd=%b wr=%b addr=%h mode=%b wdata=%h, required rd=%b wr=%b addr=%h mode=%b",
                 nm, if0.mem_is_read, if0.mem_is_write, if0.mem_address, if0.mem_mode,
                 if0.mem_write, !st, st, a, f3);
      end
    end
    n = 0;
    while (!if0.resp_valid && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles after accept, required %0d", nm, n, lat);
    end
    checks++;
    if (if0.resp_err !== e || if0.resp_rd !== exp_rd || if0.resp_data !== exp_d) begin
      errors++;
      $display("FAIL %s resp: err=%b rd=%0d data=%h, required err=%b rd=%0d data=%h",
               nm, if0.resp_err, if0.resp_rd, if0.resp_data, e, exp_rd, exp_d);
    end
    got = if0.resp_data;
    @(posedge clk); #1;
    checks++;
    if (if0.resp_valid !== 1'b0 || if0.req_ready !== 1'b1 || (strobes0 - s0) != (e ? 0 : 1)) begin
      errors++;
      $display("FAIL %s after handshake: resp_valid=%b req_ready=%b strobes=%0d, required 0 1 %0d",
               nm, if0.resp_valid, if0.req_ready, strobes0 - s0, e ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if0.resp_valid, if0.resp_err, if0.resp_rd, if0.resp_data} !== 39'd0 ||
        {if0.mem_address, if0.mem_write, if0.mem_mode} !== 67'd0 ||
        if0.mem_is_read !== 1'b0 || if0.mem_is_write !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: valid=%b err=%b rd=%0d data=%h addr=%h wdata=%h mode=%b, required all 0",
               if0.resp_valid, if0.resp_err, if0.resp_rd, if0.resp_data, if0.mem_address,
               if0.mem_write, if0.mem_mode);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if0.req_ready !== 1'b1 || if0.resp_valid !== 1'b0 || if1.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset idle: req_ready=%b resp_valid=%b dut1 req_ready=%b, required 1 0 1",
               if0.req_ready, if0.resp_valid, if1.req_ready);
    end
  endtask

  task automatic test_load_word();
    logic [31:0] got;
    poke(0, 16'h0100, 8'hDE); poke(0, 16'h0101, 8'hAD);
    poke(0, 16'h0102, 8'hBE); poke(0, 16'h0103, 8'hEF);
    run_op("load_w", 0, 3'b010, 32'h000000F0, 12'h010, 32'h0, 5'd5, got);
    checks++;
    if (got !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_w data: got %h, required deadbeef", got);
    end
  endtask

  task automatic test_store_half();
    logic [31:0] got;
    run_op("store_h", 1, 3'b001, 32'h00000200, 12'hFFE, 32'h1234ABCD, 5'd7, got);
    run_op("load_hu", 0, 3'b101, 32'h000001FE, 12'h000, 32'h0, 5'd3, got);
    checks++;
    if (got !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL load_hu data: got %h, required 0000abcd", got);
    end
    run_op("load_h", 0, 3'b001, 32'h000001FE, 12'h000, 32'h0, 5'd4, got);
    run_op("load_b", 0, 3'b000, 32'h000001FF, 12'h000, 32'h0, 5'd6, got);
  endtask

  task automatic test_errors();
    logic [31:0] got;
    run_op("err_f3_011", 0, 3'b011, 32'h00000100, 12'h000, 32'h0, 5'd1, got);
    run_op("err_store_bu", 1, 3'b100, 32'h00000100, 12'h000, 32'h55, 5'd1, got);
    run_op("err_oob_w", 0, 3'b010, 32'h0000FFFD, 12'h000, 32'h0, 5'd1, got);
    run_op("edge_w_ok", 0, 3'b010, 32'h0000FFFC, 12'h000, 32'h0, 5'd2, got);
    run_op("wrap_to_0", 0, 3'b010, 32'hFFFFFFFF, 12'h001, 32'h0, 5'd8, got);
    run_op("err_neg_wrap", 0, 3'b000, 32'h00000000, 12'hFFF, 32'h0, 5'd8, got);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d, got;
    logic [37:0] snap;
    int n, s0;
    exp_d = ref_load(32'h100, 3'b010);
    if0.resp_ready = 1'b0;
    drive0(0, 3'b010, 32'h100, 12'h000, 32'h0, 5'd9);
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    n = 0;
    while (!if0.resp_valid && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (if0.resp_valid !== 1'b1 || if0.resp_data !== exp_d || if0.resp_rd !== 5'd9) begin
      errors++;
      $display("FAIL bp resp: valid=%b data=%h rd=%0d, required 1 %h 9",
               if0.resp_valid, if0.resp_data, if0.resp_rd, exp_d);
    end
    snap = {if0.resp_err, if0.resp_rd, if0.resp_data};
    s0 = strobes0;
    drive0(1, 3'b000, 32'h40, 12'h000, 32'h77, 5'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (if0.resp_valid !== 1'b1 || {if0.resp_err, if0.resp_rd, if0.resp_data} !== snap ||
          if0.req_ready !== 1'b0 || strobes0 != s0) begin
        errors++;
        $display("FAIL bp hold %0d: valid=%b resp=%h req_ready=%b strobes=%0d, required 1 %h 0 %0d",
                 k, if0.resp_valid, {if0.resp_err, if0.resp_rd, if0.resp_data}, if0.req_ready,
                 strobes0 - s0, snap, 0);
      end
    end
    if0.req_valid  = 1'b0;
    if0.resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if0.req_ready !== 1'b1 || if0.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp release: req_ready=%b resp_valid=%b, required 1 0", if0.req_ready, if0.resp_valid);
    end
    run_op("bp_next", 1, 3'b000, 32'h40, 12'h000, 32'h77, 5'd0, got);
  endtask

  task automatic test_random();
    logic [31:0] got, base;
    logic [2:0]  f3;
    bit          st;
    logic [2:0]  legal [5];
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int k = 0; k < 40; k++) begin
      st = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       base = 32'($urandom_range(0, 65535));
        1:       base = 32'h0000FFF0 + 32'($urandom_range(0, 31));
        default: base = $urandom;
      endcase
      run_op("random", st, f3, base, 12'($urandom), $urandom, 5'($urandom), got);
    end
  endtask

  task automatic test_reset_mid_op();
    drive0(1, 3'b010, 32'h300, 12'h000, 32'hCAFEF00D, 5'd0);
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    checks++;
    if (if0.mem_is_write !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid issue: mem_is_write=%b, required 1", if0.mem_is_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if0.mem_is_write !== 1'b0 || if0.mem_is_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid gate: wr=%b rd=%b, required 0 0", if0.mem_is_write, if0.mem_is_read);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if0.resp_valid !== 1'b0 || if0.req_ready !== 1'b1 ||
        {ram0[16'h300], ram0[16'h301], ram0[16'h302], ram0[16'h303]} !==
        {refm[16'h300], refm[16'h301], refm[16'h302], refm[16'h303]}) begin
      errors++;
      $display("FAIL rst_mid after: resp_valid=%b req_ready=%b mem=%h, required 0 1 %h",
               if0.resp_valid, if0.req_ready,
               {ram0[16'h300], ram0[16'h301], ram0[16'h302], ram0[16'h303]},
               {refm[16'h300], refm[16'h301], refm[16'h302], refm[16'h303]});
    end
  endtask

  task automatic test_latency3();
    int n;
    poke(1, 16'h0100, 8'hDE); poke(1, 16'h0101, 8'hAD);
    poke(1, 16'h0102, 8'hBE); poke(1, 16'h0103, 8'hEF);
    if1.req_is_store = 1'b0;
    if1.req_funct3   = 3'b010;
    if1.req_base     = 32'hF0;
    if1.req_offset   = 12'h010;
    if1.req_wdata    = '0;
    if1.req_rd       = 5'd5;
    if1.req_valid    = 1'b1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    n = 0;
    while (!if1.resp_valid && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 1 + LAT1) begin
      errors++;
      $display("FAIL lat3 latency: got %0d cycles after accept, required %0d", n, 1 + LAT1);
    end
    checks++;
    if (if1.resp_data !== 32'hDEADBEEF || if1.resp_rd !== 5'd5 || if1.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL lat3 resp: data=%h rd=%0d err=%b, required deadbeef 5 0",
               if1.resp_data, if1.resp_rd, if1.resp_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    strobes0 = 0;
    cnt0 = 0;
    cnt1 = 0;
    rst_n = 1'b0;
    bd_we0 = 1'b0;
    bd_we1 = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    if0.req_valid = 1'b0; if0.req_is_store = 1'b0; if0.req_funct3 = '0; if0.req_base = '0;
    if0.req_offset = '0; if0.req_wdata = '0; if0.req_rd = '0; if0.resp_ready = 1'b1;
    if1.req_valid = 1'b0; if1.req_is_store = 1'b0; if1.req_funct3 = '0; if1.req_base = '0;
    if1.req_offset = '0; if1.req_wdata = '0; if1.req_rd = '0; if1.resp_ready = 1'b1;
    for (int i = 0; i < 65536; i++) refm[i] = pat(i);
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;
    test_reset();
    test_load_word();
    test_store_half();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    test_latency3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
